// File: rtl/uart_rx_if.sv
// uart_rx_if: RX FIFO read side, status and sticky error flags between uart_rx and bus logic
interface uart_rx_if #(parameter int DATA_WIDTH = 8);
  logic rx_queue_re;
  logic [DATA_WIDTH-1:0] rx_queue_dout;
  logic rx_queue_empty;
  logic rx_queue_full;
  logic rx_busy;
  logic frame_error;
  logic parity_error;
  logic overrun_error;
  logic err_clear;
  modport master (
    output rx_queue_re, err_clear,
    input rx_queue_dout, rx_queue_empty, rx_queue_full, rx_busy, frame_error, parity_error, overrun_error
  );
  modport slave (
    input rx_queue_re, err_clear,
    output rx_queue_dout, rx_queue_empty, rx_queue_full, rx_busy, frame_error, parity_error, overrun_error
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver with start/data/parity/stop deframing, RX FIFO and sticky errors
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int RX_QUEUE_SIZE = 16,
  parameter int DIVISOR_WIDTH = 16
) (
  input logic clk,
  input logic reset,
  input logic rx,
  input logic [DIVISOR_WIDTH-1:0] clk_divisor,
  input logic [1:0] data_bits_count,
  input logic [1:0] parity_type,
  input logic double_stop_bits,
  uart_rx_if.slave bus
);
  localparam int AW = $clog2(RX_QUEUE_SIZE);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t state;
  logic rx_m, rx_s, rx_p;
  logic [DIVISOR_WIDTH-1:0] div_cnt;
  logic [3:0] btick, nbits;
  logic s7, s8, push, fe_f, pe_f;
  logic [1:0] cfg_nb;
  logic cfg_par, cfg_odd, cfg_dbl;
  logic [DATA_WIDTH-1:0] shreg, chr;
  logic [DATA_WIDTH-1:0] mem [RX_QUEUE_SIZE];
  logic [AW:0] wp, rp;
  logic tick, fall, maj, samp, bound, empty, full, pop, wr;
  assign tick = div_cnt == clk_divisor;
  assign fall = rx_p & ~rx_s;
  assign maj = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign samp = tick && btick == 4'd9;
  assign bound = tick && btick == 4'd15;
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign pop = bus.rx_queue_re & ~empty;
  assign wr = push & (~full | pop);
  assign chr = shreg >> (DATA_WIDTH - 5 - int'(cfg_nb));
  assign bus.rx_queue_dout = empty ? '0 : mem[rp[AW-1:0]];
  assign bus.rx_queue_empty = empty;
  assign bus.rx_queue_full = full;
  assign bus.rx_busy = state != IDLE;
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= chr;
  always_ff @(posedge clk) begin
    if (reset) begin
      {rx_p, rx_s, rx_m} <= 3'b111;
      state <= IDLE;
      div_cnt <= '0;
      btick <= '0;
      nbits <= '0;
      {s7, s8, push, fe_f, pe_f} <= '0;
      {cfg_nb, cfg_par, cfg_odd, cfg_dbl} <= '0;
      shreg <= '0;
      wp <= '0;
      rp <= '0;
      bus.frame_error <= 1'b0;
      bus.parity_error <= 1'b0;
      bus.overrun_error <= 1'b0;
    end else begin
      {rx_p, rx_s, rx_m} <= {rx_s, rx_m, rx};
      push <= 1'b0;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      bus.frame_error <= !bus.err_clear && (bus.frame_error | (push & fe_f));
      bus.parity_error <= !bus.err_clear && (bus.parity_error | (push & pe_f));
      bus.overrun_error <= !bus.err_clear && (bus.overrun_error | (push & full & ~pop));
      if (tick && state != IDLE) begin
        btick <= btick + 1'b1;
        if (btick == 4'd7) s7 <= rx_s;
        if (btick == 4'd8) s8 <= rx_s;
      end
      case (state)
        IDLE: if (fall) begin
          state <= START;
          div_cnt <= '0;
          btick <= '0;
          nbits <= '0;
          shreg <= '0;
          fe_f <= 1'b0;
          pe_f <= 1'b0;
          cfg_nb <= data_bits_count;
          cfg_par <= parity_type[1];
          cfg_odd <= parity_type[0];
          cfg_dbl <= double_stop_bits;
        end
        START: if (samp && maj) state <= IDLE;
          else if (bound) state <= DATA;
        DATA: begin
          if (samp) begin
            shreg <= {maj, shreg[DATA_WIDTH-1:1]};
            nbits <= nbits + 1'b1;
          end
          if (bound && nbits == 4'd5 + 4'(cfg_nb)) state <= cfg_par ? PARITY : STOP1;
        end
        PARITY: begin
          if (samp) pe_f <= maj ^ (^shreg) ^ cfg_odd;
          if (bound) state <= STOP1;
        end
        STOP1: if (samp) begin
          fe_f <= ~maj;
          if (!cfg_dbl) begin
            push <= 1'b1;
            state <= IDLE;
          end
        end else if (bound) state <= STOP2;
        STOP2: if (samp) begin
          fe_f <= fe_f | ~maj;
          push <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
